// File: rtl/v_decoders_scan.sv
// Registered 1-of-N decoder with direct-load and auto-scan modes.
// Drives row/digit strobes with programmable dwell and blanking.
module v_decoders_scan #(
  parameter int SEL_WIDTH  = 3,
  parameter int ACTIVE_LOW = 1,
  parameter int DWELL      = 4,
  parameter int BLANK      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic                    load,
  input  logic [SEL_WIDTH-1:0]    sel,
  input  logic                    en,
  output logic [2**SEL_WIDTH-1:0] res,
  output logic [SEL_WIDTH-1:0]    idx,
  output logic                    wrap
);

  localparam int N  = 2**SEL_WIDTH;
  localparam int MX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW = (MX > 1) ? $clog2(MX) : 1;

  localparam logic [N-1:0]  INACT = {N{ACTIVE_LOW != 0}};
  localparam logic [CW-1:0] DLAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLAST = CW'((BLANK > 0) ? BLANK - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN_ON,
    SCAN_BLANK
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [SEL_WIDTH-1:0] nxt;
  logic [SEL_WIDTH-1:0] dsel;

  function automatic logic [N-1:0] dec(input logic [SEL_WIDTH-1:0] i);
    logic [N-1:0] d;
    d    = '0;
    d[i] = 1'b1;
    return (ACTIVE_LOW != 0) ? ~d : d;
  endfunction

  assign nxt  = idx + 1'b1;
  assign dsel = load ? sel : idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      res   <= INACT;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (!en) begin
        // Blank the lines but keep scan position so dwell resumes intact.
        res <= INACT;
        if (state == DIRECT && load && !mode) idx <= sel;
      end else begin
        unique case (state)
          IDLE: begin
            if (mode) begin
              state <= SCAN_ON;
              cnt   <= '0;
              res   <= dec(idx);
            end else if (load) begin
              state <= DIRECT;
              idx   <= sel;
              res   <= dec(sel);
            end else begin
              res <= INACT;
            end
          end
          DIRECT: begin
            if (mode) begin
              state <= SCAN_ON;
              cnt   <= '0;
              res   <= dec(idx);
            end else begin
              idx <= dsel;
              res <= dec(dsel);
            end
          end
          SCAN_ON: begin
            if (!mode) begin
              state <= DIRECT;
              cnt   <= '0;
              idx   <= dsel;
              res   <= dec(dsel);
            end else if (cnt == DLAST) begin
              cnt <= '0;
              if (BLANK > 0) begin
                state <= SCAN_BLANK;
                res   <= INACT;
              end else begin
                idx  <= nxt;
                res  <= dec(nxt);
                wrap <= (nxt == '0);
              end
            end else begin
              cnt <= cnt + 1'b1;
              res <= dec(idx);
            end
          end
          SCAN_BLANK: begin
            if (!mode) begin
              state <= DIRECT;
              cnt   <= '0;
              idx   <= dsel;
              res   <= dec(dsel);
            end else if (cnt == BLAST) begin
              state <= SCAN_ON;
              cnt   <= '0;
              idx   <= nxt;
              res   <= dec(nxt);
              wrap  <= (nxt == '0);
            end else begin
              cnt <= cnt + 1'b1;
              res <= INACT;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_v_decoders_scan.sv
// Bench for v_decoders_scan: directed plan steps plus random traffic
// compared against a period-based behavioural model.
module tb_v_decoders_scan;

  logic       clk = 1'b0;
  logic       rst, mode, load, en;
  logic [2:0] sel;
  logic [7:0] res;
  logic [2:0] idx;
  logic       wrap;

  logic       rst1, mode1, load1, en1;
  logic [1:0] sel1;
  logic [3:0] res1;
  logic [1:0] idx1;
  logic       wrap1;

  int errs = 0;
  int checks = 0;

  // model state: st 0=idle 1=direct 2=scan; t = position in step period
  int         m_st, m_idx, m_t;
  logic [7:0] m_res;
  logic       m_wrap;

  localparam int DW = 4;
  localparam int PER = 5;

  always #5 clk = ~clk;

  v_decoders_scan u0 (
    .clk(clk), .rst(rst), .mode(mode), .load(load),
    .sel(sel), .en(en), .res(res), .idx(idx), .wrap(wrap)
  );

  v_decoders_scan #(
    .SEL_WIDTH(2), .ACTIVE_LOW(0), .DWELL(1), .BLANK(0)
  ) u1 (
    .clk(clk), .rst(rst1), .mode(mode1), .load(load1),
    .sel(sel1), .en(en1), .res(res1), .idx(idx1), .wrap(wrap1)
  );

  function automatic logic [7:0] decm(input int i);
    logic [7:0] one;
    one = 8'h01 << i;
    return ~one;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_st = 0; m_idx = 0; m_t = 0; m_res = 8'hFF; m_wrap = 1'b0;
    end else if (!en) begin
      m_wrap = 1'b0;
      m_res = 8'hFF;
      if (m_st == 1 && load && !mode) m_idx = sel;
    end else begin
      m_wrap = 1'b0;
      if (m_st == 2 && !mode) begin
        m_st = 1;
        if (load) m_idx = sel;
        m_t = 0;
        m_res = decm(m_idx);
      end else if (m_st == 2) begin
        m_t++;
        if (m_t == PER) begin
          m_t = 0;
          m_idx = (m_idx + 1) % 8;
          m_wrap = (m_idx == 0);
        end
        m_res = (m_t < DW) ? decm(m_idx) : 8'hFF;
      end else if (mode) begin
        m_st = 2;
        m_t = 0;
        m_res = decm(m_idx);
      end else if (load || m_st == 1) begin
        m_st = 1;
        if (load) m_idx = sel;
        m_res = decm(m_idx);
      end else begin
        m_res = 8'hFF;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("model_res", res, m_res);
    chk("model_idx", idx, m_idx);
    chk("model_wrap", wrap, m_wrap);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; load = 1'b0; sel = 3'd0; en = 1'b1;
    rst1 = 1'b1; mode1 = 1'b0; load1 = 1'b0; sel1 = 2'd0; en1 = 1'b1;
    m_st = 0; m_idx = 0; m_t = 0; m_res = 8'hFF; m_wrap = 1'b0;

    // reset
    run(2);
    chk("rst_res", res, 8'hFF);
    chk("rst_idx", idx, 3'd0);
    chk("rst_wrap", wrap, 1'b0);
    rst = 1'b0;
    run(2);
    chk("idle_res", res, 8'hFF);
    chk("idle_idx", idx, 3'd0);

    // direct load
    load = 1'b1; sel = 3'd3;
    cyc();
    chk("load3_res", res, 8'hF7);
    chk("load3_idx", idx, 3'd3);
    load = 1'b0; sel = 3'd5;
    cyc();
    chk("hold_res", res, 8'hF7);
    chk("hold_idx", idx, 3'd3);

    // scan with wrap
    load = 1'b1; sel = 3'd6;
    cyc();
    chk("load6_res", res, 8'hBF);
    load = 1'b0; mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("row6", res, 8'hBF);
    end
    cyc();
    chk("blank6", res, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("row7", res, 8'h7F);
      chk("row7_wrap", wrap, 1'b0);
    end
    cyc();
    chk("blank7", res, 8'hFF);
    cyc();
    chk("row0_res", res, 8'hFE);
    chk("row0_wrap", wrap, 1'b1);
    chk("row0_idx", idx, 3'd0);
    cyc();
    chk("row0_wrap_end", wrap, 1'b0);
    chk("row0_res2", res, 8'hFE);

    // walk to row 2, two cycles in
    run(2);
    cyc();
    chk("blank0", res, 8'hFF);
    run(5);
    cyc();
    chk("row2_a", res, 8'hFB);
    cyc();
    chk("row2_b", res, 8'hFB);

    // enable freeze
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("frz_res", res, 8'hFF);
      chk("frz_idx", idx, 3'd2);
    end
    en = 1'b1;
    cyc();
    chk("resume_a", res, 8'hFB);
    cyc();
    chk("resume_b", res, 8'hFB);
    cyc();
    chk("resume_blank", res, 8'hFF);

    // to row 5, then reset mid-scan
    cyc();
    chk("row3", res, 8'hF7);
    run(4);
    cyc();
    chk("row4", res, 8'hEF);
    run(4);
    cyc();
    chk("row5", res, 8'hDF);
    rst = 1'b1;
    cyc();
    chk("mrst_res", res, 8'hFF);
    chk("mrst_idx", idx, 3'd0);
    chk("mrst_wrap", wrap, 1'b0);
    rst = 1'b0;
    cyc();
    chk("restart_res", res, 8'hFE);
    chk("restart_wrap", wrap, 1'b0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      en   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 11) == 0) mode = ~mode;
      load = ($urandom_range(0, 2) == 0);
      sel  = 3'($urandom_range(0, 7));
      cyc();
    end

    // one-hot, no blank, dwell 1
    rst = 1'b0; en = 1'b1; mode = 1'b1; load = 1'b0;
    cyc();
    mode1 = 1'b1;
    cyc();
    rst1 = 1'b0;
    for (int k = 0; k < 9; k++) begin
      logic [3:0] e1;
      e1 = 4'b0001 << (k % 4);
      cyc();
      chk("oh_res", res1, e1);
      chk("oh_wrap", wrap1, (k > 0 && k % 4 == 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
